payment_controller: RTL

//  Coin-credit stage directly upstream of product_selector. Accumulates inserted coins and compares

---
 rtl/vending_pkg.sv | 33 +++
 rtl/change_greedy_sel.sv | 32 +++
 rtl/payment_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared vending definitions: coin encodings and unit values, controller state encoding,
// and the coin_value() helper used by payment_controller, product_selector and the bench.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_5    = 2'b11;

  localparam logic [2:0] UNITS_1 = 3'd1;
  localparam logic [2:0] UNITS_2 = 3'd2;
  localparam logic [2:0] UNITS_5 = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_COLLECT  = 2'b01,
    ST_DISPENSE = 2'b10,
    ST_CHANGE   = 2'b11
  } vend_state_e;

  // Unit value of an encoded coin; the illegal code is worth nothing.
  function automatic logic [2:0] coin_value(input logic [1:0] coin);
    logic [2:0] units;
    case (coin)
      COIN_1:  units = UNITS_1;
      COIN_2:  units = UNITS_2;
      COIN_5:  units = UNITS_5;
      default: units = 3'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/change_greedy_sel.sv
// Greedy change selector: picks the largest coin not exceeding the remaining credit.
// Purely combinational; returns the coin encoding and its unit value.
module change_greedy_sel
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          change_coin,
  output logic [2:0]          coin_units
);

  // Largest denomination first.
  always_comb begin
    change_coin = COIN_NONE;
    coin_units  = 3'd0;
    if (credit >= CREDIT_W'(5)) begin
      change_coin = COIN_5;
      coin_units  = UNITS_5;
    end else if (credit >= CREDIT_W'(2)) begin
      change_coin = COIN_2;
      coin_units  = UNITS_2;
    end else if (credit != {CREDIT_W{1'b0}}) begin
      change_coin = COIN_1;
      coin_units  = UNITS_1;
    end else begin
      change_coin = COIN_NONE;
      coin_units  = 3'd0;
    end
  end

endmodule

// File: rtl/payment_controller.sv
// Coin-credit controller upstream of product_selector: collects coins, buys, dispenses, returns change.
// Optional idle auto-refund in COLLECT is enabled by defining PAYMENT_TIMEOUT_EN.
module payment_controller
  import vending_pkg::*;
#(
  parameter int CREDIT_W       = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  input  logic                cancel,
  input  logic                price_valid,
  input  logic [4:0]          product_price,
  input  logic                product_dispense_done,
  output logic                product_dispense_en,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                busy
);

  localparam logic [CREDIT_W:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};

  vend_state_e         state_r, state_s;
  logic [CREDIT_W-1:0] credit_r, credit_s;
  logic                coin_reject_r, coin_reject_s;
  logic                insufficient_r, insufficient_s;
  logic                change_valid_r, change_valid_s;
  logic [1:0]          change_coin_r, change_coin_s;
  logic                dispense_en_r;
  logic                busy_r;
  logic                coin_acc_s;
  logic                timeout_s;
  logic [2:0]          coin_units_s;
  logic [CREDIT_W:0]   coin_sum_s;
  logic                coin_ok_s;
  logic                buy_s;
  logic [CREDIT_W-1:0] price_ext_s;
  logic [1:0]          sel_coin_s;
  logic [2:0]          sel_units_s;

  change_greedy_sel #(.CREDIT_W(CREDIT_W)) u_change_sel (
    .credit      (credit_r),
    .change_coin (sel_coin_s),
    .coin_units  (sel_units_s)
  );

  // The sum is one bit wider so an overflowing coin is detectable instead of wrapping.
  assign coin_units_s = coin_value(coin_val);
  assign coin_sum_s   = {1'b0, credit_r} + (CREDIT_W+1)'(coin_units_s);
  assign coin_ok_s    = coin_valid && (coin_val != COIN_NONE) && (coin_sum_s <= MAX_CREDIT);
  assign buy_s        = price_valid && (product_price != 5'd0);
  assign price_ext_s  = CREDIT_W'(product_price);

`ifdef PAYMENT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt_r;

  assign timeout_s = (state_r == ST_COLLECT) && (idle_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter; restarts on COLLECT entry and on every accepted coin.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_r <= {TO_W{1'b0}};
    end else if ((state_r != ST_COLLECT) || (state_s != ST_COLLECT) || coin_acc_s) begin
      idle_cnt_r <= {TO_W{1'b0}};
    end else begin
      idle_cnt_r <= idle_cnt_r + TO_W'(1);
    end
  end
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
  assign timeout_s        = 1'b0;
`endif

  // Next state, next credit and next pulse outputs; in COLLECT cancel beats purchase beats coin.
  always_comb begin
    state_s        = state_r;
    credit_s       = credit_r;
    coin_reject_s  = 1'b0;
    insufficient_s = 1'b0;
    change_valid_s = 1'b0;
    change_coin_s  = COIN_NONE;
    coin_acc_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (coin_ok_s) begin
          credit_s   = coin_sum_s[CREDIT_W-1:0];
          coin_acc_s = 1'b1;
          state_s    = ST_COLLECT;
        end else begin
          coin_reject_s = coin_valid;
        end
      end
      ST_COLLECT: begin
        if (cancel || timeout_s) begin
          state_s       = ST_CHANGE;
          coin_reject_s = coin_valid;
        end else if (buy_s && (credit_r >= price_ext_s)) begin
          credit_s      = credit_r - price_ext_s;
          state_s       = ST_DISPENSE;
          coin_reject_s = coin_valid;
        end else begin
          insufficient_s = buy_s;
          if (coin_ok_s) begin
            credit_s   = coin_sum_s[CREDIT_W-1:0];
            coin_acc_s = 1'b1;
          end else begin
            coin_reject_s = coin_valid;
          end
        end
      end
      ST_DISPENSE: begin
        coin_reject_s = coin_valid;
        if (product_dispense_done) begin
          state_s = (credit_r != {CREDIT_W{1'b0}}) ? ST_CHANGE : ST_IDLE;
        end else begin
          state_s = ST_DISPENSE;
        end
      end
      ST_CHANGE: begin
        coin_reject_s = coin_valid;
        if (credit_r != {CREDIT_W{1'b0}}) begin
          change_valid_s = 1'b1;
          change_coin_s  = sel_coin_s;
          credit_s       = credit_r - CREDIT_W'(sel_units_s);
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        credit_s = {CREDIT_W{1'b0}};
      end
    endcase
  end

  // State, credit and every output are flops; reset drops credit without refund.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      credit_r       <= {CREDIT_W{1'b0}};
      coin_reject_r  <= 1'b0;
      insufficient_r <= 1'b0;
      change_valid_r <= 1'b0;
      change_coin_r  <= COIN_NONE;
      dispense_en_r  <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      credit_r       <= credit_s;
      coin_reject_r  <= coin_reject_s;
      insufficient_r <= insufficient_s;
      change_valid_r <= change_valid_s;
      change_coin_r  <= change_coin_s;
      dispense_en_r  <= (state_s == ST_DISPENSE);
      busy_r         <= (state_s == ST_DISPENSE) || (state_s == ST_CHANGE);
    end
  end

  assign product_dispense_en = dispense_en_r;
  assign credit              = credit_r;
  assign coin_reject         = coin_reject_r;
  assign insufficient        = insufficient_r;
  assign change_valid        = change_valid_r;
  assign change_coin         = change_coin_r;
  assign busy                = busy_r;

endmodule
